// File: rtl/dcache_wb_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_wb_ctrl
//   Direct-mapped, write-back, write-allocate data cache sitting between the
//   pipeline MEM stage and a line-wide off-chip data memory.
//   - Hits: a load returns its word in the access cycle. A store writes the
//     word and marks the line dirty at the next clock edge. Neither stalls.
//   - Misses: cpu_stall_o rises in the same cycle. A dirty victim is written
//     back (WBACK), then the line is fetched (FILL). DONE adds one more stall
//     cycle, after which the retried access hits in IDLE.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-low
//   cpu_req_i    access request from EX/MEM (MemRead | MemWrite)
//   cpu_we_i     1 = store word, 0 = load word
//   cpu_addr_i   byte address; bits [1:0] ignored
//   cpu_wdata_i  store data
//   cpu_rdata_o  load data; valid when cpu_req_i & ~cpu_we_i & ~cpu_stall_o
//   cpu_stall_o  freeze PC and every pipeline register
//   mem_req_o    line request to memory; held until mem_ack_i
//   mem_we_o     1 = line write-back, 0 = line fill
//   mem_addr_o   line-aligned memory address
//   mem_wdata_o  victim line for write-back
//   mem_ack_i    one-cycle completion pulse; mem_rdata_i valid with it
//   mem_rdata_i  fill data
// -----------------------------------------------------------------------------
module dcache_wb_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WORDS  = LINE_BITS / 32;
  localparam int WOFF_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WBACK,
    FILL,
    DONE
  } state_t;

  state_t state;

  // Storage: each line is viewed as an array of 32-bit words so word
  // selection and word writes need no bit arithmetic.
  logic [WORDS-1:0][31:0] data_mem [NUM_LINES];
  logic [TAG_W-1:0]       tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0]   valid;
  logic [NUM_LINES-1:0]   dirty;

  // Miss context, captured when the miss is detected so the transaction
  // completes correctly even if cpu_req_i drops part-way through.
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;

  // Address decode of the current CPU access.
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WOFF_W-1:0] woff;
  logic [1:0]        unused_byte_off;

  assign idx             = cpu_addr_i[OFF_W +: IDX_W];
  assign tag             = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign woff            = cpu_addr_i[2 +: WOFF_W];
  assign unused_byte_off = cpu_addr_i[1:0];

  // Lookup only in IDLE; other states are busy with the miss in flight.
  logic hit;
  logic store_hit;
  logic fill_done;

  assign hit       = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);
  assign store_hit = hit && cpu_req_i && cpu_we_i;
  assign fill_done = (state == FILL) && mem_ack_i;

  // Stall and load data are gated by reset so the pipeline sees an idle
  // cache the instant reset asserts, whatever the CPU is requesting.
  assign cpu_stall_o = rst_i &&
                       (((state == IDLE) && cpu_req_i && !hit) || (state != IDLE));

  always_comb begin
    // NOTE: every always_comb output gets a default first; a missing else
    // path would otherwise infer a latch.
    cpu_rdata_o = '0;
    if (rst_i && hit && cpu_req_i && !cpu_we_i) begin
      cpu_rdata_o = data_mem[idx][woff];
    end
  end

  // Tag and data arrays: plain clocked storage, written on a store hit or
  // when fill data arrives.
  // NOTE: large arrays carry no reset; valid bits (reset below) make their
  // power-up contents irrelevant, and a reset term would block RAM mapping.
  always_ff @(posedge clk_i) begin
    if (store_hit) begin
      data_mem[idx][woff] <= cpu_wdata_i;
    end
    if (fill_done) begin
      data_mem[miss_idx] <= mem_rdata_i;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

  // Controller FSM with registered memory-side outputs. The mem_* registers
  // change only on state transitions, so they are stable while mem_req_o=1.
  // A write-back ack moves straight into the fill request, keeping mem_req_o
  // high; this gives 2L+2 stall cycles for a dirty miss instead of 2L+3.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state       <= IDLE;
      valid       <= '0;
      dirty       <= '0;
      miss_idx    <= '0;
      miss_tag    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit) begin
            dirty[idx] <= 1'b1;
          end else if (cpu_req_i && !hit) begin
            miss_idx  <= idx;
            miss_tag  <= tag;
            mem_req_o <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {tag_mem[idx], idx, {OFF_W{1'b0}}};
              mem_wdata_o <= data_mem[idx];
              state       <= WBACK;
            end else begin
              mem_we_o   <= 1'b0;
              mem_addr_o <= {tag, idx, {OFF_W{1'b0}}};
              state      <= FILL;
            end
          end
        end

        WBACK: begin
          if (mem_ack_i) begin
            dirty[miss_idx] <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
            state           <= FILL;
          end
        end

        FILL: begin
          if (mem_ack_i) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            mem_req_o       <= 1'b0;
            state           <= DONE;
          end
        end

        DONE: begin
          // One extra stall cycle; the retried access then hits in IDLE.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_wb_ctrl
//   Scoreboard bench for dcache_wb_ctrl. Stimulus pushes the expected load
//   data and expected memory transactions into queues. Two monitors pop and
//   compare: one whenever a load completes (req & ~we & ~stall), the other
//   whenever the cache opens a new memory request. A memory responder acks
//   each request in its L-th cycle and serves lines from a backing store that
//   absorbs write-backs.
// -----------------------------------------------------------------------------
module tb_dcache_wb_ctrl;

  localparam int L = 3;  // memory ack latency in cycles of mem_req_o high

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic         chk_wd;
    logic [255:0] wdata;
  } mem_exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_rdata_i = '0;

  int errors = 0;
  int checks = 0;
  int req_cycles = 0;

  mem_exp_t     mem_q[$];
  logic [31:0]  rd_q[$];
  logic [255:0] backing [logic [31:0]];

  dcache_wb_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lines never written back hold their own byte addresses as word values.
  function automatic logic [255:0] default_line(input logic [31:0] a);
    logic [255:0] l;
    for (int j = 0; j < 8; j++) l[j*32 +: 32] = a + 32'(j * 4);
    return l;
  endfunction

  // Memory responder and memory-transaction monitor (one process, so the
  // ack it drives and the transaction boundaries it tracks never race).
  initial begin
    int       cnt;
    bit       in_txn;
    mem_exp_t e;
    cnt    = 0;
    in_txn = 0;
    forever begin
      @(negedge clk_i);
      if (mem_ack_i) begin
        in_txn = 0;
        cnt    = 0;
      end
      if (mem_req_o) begin
        req_cycles++;
        if (!in_txn) begin
          in_txn = 1;
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected mem request: we=%0b addr=%0h, none expected", mem_we_o, mem_addr_o);
          end else begin
            e = mem_q.pop_front();
            check("mem_we", {255'b0, mem_we_o}, {255'b0, e.we});
            check("mem_addr", {224'b0, mem_addr_o}, {224'b0, e.addr});
            if (e.chk_wd) check("mem_wdata", mem_wdata_o, e.wdata);
          end
        end
        cnt++;
        if (cnt == L) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) backing[mem_addr_o] = mem_wdata_o;
          mem_rdata_i = backing.exists(mem_addr_o) ? backing[mem_addr_o] : default_line(mem_addr_o);
        end else begin
          mem_ack_i = 1'b0;
        end
      end else begin
        mem_ack_i = 1'b0;
        in_txn    = 0;
        cnt       = 0;
      end
    end
  end

  // Load-data monitor.
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk_i);
      if (rst_i && cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected load completion: addr=%0h data=%0h", cpu_addr_i, cpu_rdata_o);
        end else begin
          exp = rd_q.pop_front();
          check("load data", {224'b0, cpu_rdata_o}, {224'b0, exp});
        end
      end
    end
  end

  // Issue one access starting just after a rising edge; returns the number
  // of cycles it stalled. Leaves the bench just after the retiring edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int stalls);
    bit done;
    done        = 0;
    stalls      = 0;
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) done = 1;
      else stalls++;
      @(posedge clk_i);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access timeout: addr=%0h still stalled after 100 cycles", addr);
    end
    cpu_req_i = 1'b0;
  endtask

  task automatic load(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                      input int exp_stalls, output int stalls);
    rd_q.push_back(exp_data);
    access(1'b0, addr, 32'h0, stalls);
    check({name, " stalls"}, 256'(stalls), 256'(exp_stalls));
  endtask

  task automatic store(input string name, input logic [31:0] addr, input logic [31:0] data,
                       input int exp_stalls);
    int s;
    access(1'b1, addr, data, s);
    check({name, " stalls"}, 256'(s), 256'(exp_stalls));
  endtask

  task automatic expect_mem(input logic we, input logic [31:0] addr, input logic chk_wd,
                            input logic [255:0] wdata);
    mem_exp_t e;
    e.we     = we;
    e.addr   = addr;
    e.chk_wd = chk_wd;
    e.wdata  = wdata;
    mem_q.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line40;
    logic [255:0] line440;
    logic [255:0] victim;
    logic [31:0]  a;
    int           s;
    int           sum;
    int           req_snap;

    for (int j = 0; j < 8; j++) begin
      line40[j*32 +: 32]  = 32'h4000_0000 | 32'(j);
      line440[j*32 +: 32] = 32'h4400_0000 | 32'(j);
    end
    line40[95:64]   = 32'hDEAD_BEEF;
    backing[32'h40]  = line40;
    backing[32'h440] = line440;

    // Reset state
    #2;
    check("reset cpu_stall_o", {255'b0, cpu_stall_o}, 256'd0);
    check("reset mem_req_o",   {255'b0, mem_req_o},   256'd0);
    check("reset mem_we_o",    {255'b0, mem_we_o},    256'd0);
    check("reset mem_addr_o",  {224'b0, mem_addr_o},  256'd0);
    check("reset mem_wdata_o", mem_wdata_o,           256'd0);
    check("reset cpu_rdata_o", {224'b0, cpu_rdata_o}, 256'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    // T1: cold miss fill, then hit on another word of the line
    expect_mem(1'b0, 32'h40, 1'b0, '0);
    load("T1 miss 0x40", 32'h40, 32'h4000_0000, L + 2, s);
    load("T1 hit 0x48", 32'h48, 32'hDEAD_BEEF, 0, s);

    // T2: store hit, then read it back
    store("T2 store 0x44", 32'h44, 32'h1234_5678, 0);
    load("T2 load 0x44", 32'h44, 32'h1234_5678, 0, s);

    // T3: conflicting tag, dirty victim written back before the fill
    victim          = line40;
    victim[63:32]   = 32'h1234_5678;
    expect_mem(1'b1, 32'h40, 1'b1, victim);
    expect_mem(1'b0, 32'h440, 1'b0, '0);
    load("T3 dirty miss 0x440", 32'h440, 32'h4400_0000, 2 * L + 2, s);

    // T4: reset during FILL aborts the request; the line misses again
    expect_mem(1'b0, 32'h40, 1'b0, '0);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h40;
    @(posedge clk_i);
    #1;
    check("T4 fill requested", {255'b0, mem_req_o}, 256'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check("T4 reset mem_req_o",   {255'b0, mem_req_o},   256'd0);
    check("T4 reset cpu_stall_o", {255'b0, cpu_stall_o}, 256'd0);
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    expect_mem(1'b0, 32'h40, 1'b0, '0);
    load("T4 refetch 0x40", 32'h40, 32'h4000_0000, L + 2, s);
    load("T4 written-back word", 32'h44, 32'h1234_5678, 0, s);

    // T5: warm all 32 indices, then back-to-back hits with no stalls
    for (int i = 0; i < 32; i++) begin
      a = 32'(i * 32);
      if (i == 2) begin
        load("T5 warm resident", a, 32'h4000_0000, 0, s);
      end else begin
        expect_mem(1'b0, a, 1'b0, '0);
        load("T5 warm miss", a, a, L + 2, s);
      end
    end
    req_snap = req_cycles;
    sum      = 0;
    for (int i = 0; i < 32; i++) begin
      a = 32'(i * 32 + (i % 8) * 4);
      load("T5 hit", a, (i == 2) ? 32'hDEAD_BEEF : a, 0, s);
      sum += s;
    end
    check("T5 total stalls", 256'(sum), 256'd0);
    check("T5 mem_req cycles", 256'(req_cycles - req_snap), 256'd0);

    // T6: drop cpu_req_i mid-FILL; the fill still completes
    expect_mem(1'b0, 32'h1000, 1'b0, '0);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h1000;
    @(posedge clk_i);
    #1;
    check("T6 fill requested", {255'b0, mem_req_o}, 256'd1);
    cpu_req_i = 1'b0;
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end
    check("T6 idle stall", {255'b0, cpu_stall_o}, 256'd0);
    check("T6 idle mem_req", {255'b0, mem_req_o}, 256'd0);
    req_snap = req_cycles;
    repeat (5) begin
      @(posedge clk_i);
      #1;
    end
    check("T6 no further mem_req", 256'(req_cycles - req_snap), 256'd0);
    load("T6 line resident", 32'h1004, 32'h1004, 0, s);

    repeat (3) @(posedge clk_i);
    check("mem expectations drained", 256'(mem_q.size()), 256'd0);
    check("load expectations drained", 256'(rd_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
